// File: rtl/seven_seg_scan_controller.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_controller
//
// Purpose:
//   Time-multiplexes NUM_DIGITS common-anode 7-segment digits onto a single
//   segment bus. Each digit gets one slot of REFRESH_DIV cycles. The first
//   BLANK_CYCLES of every slot keep all anodes off so the previous digit's
//   segments cannot ghost onto the next one. The segment pattern comes from
//   an external shared hex-to-7-seg decoder: this block presents the current
//   nibble on digit_value and registers the decoder's answer from seg_in.
//
//   The display word is double buffered. A new word is taken into a pending
//   buffer through a valid/ready handshake and only becomes the active word
//   at a frame boundary, so a frame never mixes digits from two words.
//   Leading-zero suppression (live input) and per-digit decimal points are
//   supported.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous reset, active low
//   load_valid   in   new display word offered
//   load_ready   out  pending buffer is empty, a word can be accepted
//   load_value   in   4*NUM_DIGITS nibbles, nibble i = digit i (0 = rightmost)
//   load_dp      in   per-digit decimal point, 1 = lit
//   lz_suppress  in   1 = blank leading zeros
//   digit_value  out  nibble for the shared decoder (combinational)
//   seg_in       in   decoder result for digit_value, {g..a}, 0 = on
//   seg_n        out  segment drive {g..a}, 0 = on
//   dp_n         out  decimal point drive, 0 = on
//   an_n         out  anode enables, 0 = digit on, at most one low
//   frame_done   out  one-cycle pulse after the last digit's slot ends
// ---------------------------------------------------------------------------
module seven_seg_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  input  logic                    lz_suppress,
  output logic [3:0]              digit_value,
  input  logic [6:0]              seg_in,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done
);

  localparam int IDX_W  = $clog2(NUM_DIGITS);
  localparam int SLOT_W = $clog2(REFRESH_DIV);

  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(REFRESH_DIV - 1);
  localparam logic [SLOT_W-1:0] BLANK_LAST = SLOT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0]  DIGIT_LAST = IDX_W'(NUM_DIGITS - 1);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  logic [0:0]              state;
  logic [IDX_W-1:0]        digit_idx;
  logic [SLOT_W-1:0]       slot_cnt;

  logic [4*NUM_DIGITS-1:0] active_value;
  logic [NUM_DIGITS-1:0]   active_dp;
  logic [4*NUM_DIGITS-1:0] pend_value;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic                    pend_full;

  logic                    slot_end;
  logic                    frame_end;
  logic [NUM_DIGITS-1:0]   lead_zero;
  logic                    suppressed;
  logic [NUM_DIGITS-1:0]   an_show;
  logic                    zero_run;

  assign slot_end   = (slot_cnt == SLOT_LAST);
  assign frame_end  = slot_end && (state == ST_SHOW) && (digit_idx == DIGIT_LAST);
  assign load_ready = !pend_full;

  // The nibble index is just digit_idx scaled by four.
  assign digit_value = active_value[{digit_idx, 2'b00} +: 4];

  // lead_zero[i] is set when every nibble from the top digit down to digit i
  // is zero, i.e. digit i is part of the run of leading zeros.
  always_comb begin
    zero_run  = 1'b1;
    lead_zero = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run && (active_value[4*i +: 4] == 4'h0);
      lead_zero[i] = zero_run;
    end
  end

  // Digit 0 always shows, so a value of zero still displays a single "0".
  assign suppressed = lz_suppress && (digit_idx != '0) && lead_zero[digit_idx];

  always_comb begin
    an_show            = '1;
    an_show[digit_idx] = 1'b0;
  end

  // Slot timing: BLANK for the first BLANK_CYCLES counts of a slot, SHOW for
  // the rest; the digit index advances when the slot counter wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_BLANK;
      slot_cnt  <= '0;
      digit_idx <= '0;
    end else if (slot_end) begin
      slot_cnt  <= '0;
      state     <= ST_BLANK;
      digit_idx <= (digit_idx == DIGIT_LAST) ? '0 : digit_idx + 1'b1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
      if (slot_cnt == BLANK_LAST) begin
        state <= ST_SHOW;
      end
    end
  end

  // Double buffer. A word can only be accepted while the pending buffer is
  // empty, and the commit only happens while it is full, so the two updates
  // never hit pend_full on the same edge. A word accepted on the frame-end
  // edge therefore waits for the following frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_value <= '0;
      active_dp    <= '0;
      pend_value   <= '0;
      pend_dp      <= '0;
      pend_full    <= 1'b0;
    end else begin
      if (frame_end && pend_full) begin
        active_value <= pend_value;
        active_dp    <= pend_dp;
        pend_full    <= 1'b0;
      end
      if (load_valid && load_ready) begin
        pend_value <= load_value;
        pend_dp    <= load_dp;
        pend_full  <= 1'b1;
      end
    end
  end

  // Registered pin drive, one cycle behind the state/index it reflects.
  // A suppressed digit blanks its segments but keeps its decimal point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_n       <= '1;
      seg_n      <= SEG_OFF;
      dp_n       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (state == ST_SHOW) begin
        an_n  <= an_show;
        dp_n  <= ~active_dp[digit_idx];
        seg_n <= suppressed ? SEG_OFF : seg_in;
      end else begin
        an_n  <= '1;
        seg_n <= SEG_OFF;
        dp_n  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_scan_controller
//
// Purpose:
//   Directed self-checking bench for seven_seg_scan_controller with
//   NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2 (32-cycle frames). A small
//   hex-to-7-seg decoder stands in for the shared external decoder.
// ---------------------------------------------------------------------------
module tb_seven_seg_scan_controller;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int BC = 2;
  localparam int FRAME = ND * RD;

  logic          clk;
  logic          rst_n;
  logic          load_valid;
  logic          load_ready;
  logic [15:0]   load_value;
  logic [3:0]    load_dp;
  logic          lz_suppress;
  logic [3:0]    digit_value;
  logic [6:0]    seg_in;
  logic [6:0]    seg_n;
  logic          dp_n;
  logic [3:0]    an_n;
  logic          frame_done;

  int checks;
  int failures;

  // One captured frame of pin activity, sampled on falling edges.
  logic [3:0] an_s  [FRAME];
  logic [6:0] seg_s [FRAME];
  logic       dp_s  [FRAME];
  logic       fd_s  [FRAME];
  logic       rdy_s [FRAME];

  seven_seg_scan_controller #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_value (load_value),
    .load_dp    (load_dp),
    .lz_suppress(lz_suppress),
    .digit_value(digit_value),
    .seg_in     (seg_in),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .an_n       (an_n),
    .frame_done (frame_done)
  );

  // Common-anode decoder, {g..a}, 0 = segment on.
  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    case (h)
      4'h0: hex2seg = 7'h40;
      4'h1: hex2seg = 7'h79;
      4'h2: hex2seg = 7'h24;
      4'h3: hex2seg = 7'h30;
      4'h4: hex2seg = 7'h19;
      4'h5: hex2seg = 7'h12;
      4'h6: hex2seg = 7'h02;
      4'h7: hex2seg = 7'h78;
      4'h8: hex2seg = 7'h00;
      4'h9: hex2seg = 7'h10;
      4'hA: hex2seg = 7'h08;
      4'hB: hex2seg = 7'h03;
      4'hC: hex2seg = 7'h46;
      4'hD: hex2seg = 7'h21;
      4'hE: hex2seg = 7'h06;
      default: hex2seg = 7'h0E;
    endcase
  endfunction

  assign seg_in = hex2seg(digit_value);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Waits (bounded) for a falling edge where frame_done is high.
  task automatic wait_frame(output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  // Records the next full frame, starting from a frame_done falling edge.
  task automatic capture_frame();
    for (int e = 0; e < FRAME; e++) begin
      @(negedge clk);
      an_s[e]  = an_n;
      seg_s[e] = seg_n;
      dp_s[e]  = dp_n;
      fd_s[e]  = frame_done;
      rdy_s[e] = load_ready;
    end
  endtask

  // Offers one word for a single cycle.
  task automatic load_word(input logic [15:0] v, input logic [3:0] dp);
    load_value = v;
    load_dp    = dp;
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic test_reset();
    bit to;
    rst_n       = 1'b0;
    load_valid  = 1'b0;
    load_value  = '0;
    load_dp     = '0;
    lz_suppress = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (an_n !== 4'hF || seg_n !== 7'h7F || dp_n !== 1'b1 || frame_done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: an_n=%h seg_n=%h dp_n=%b fd=%b, want F 7f 1 0",
               an_n, seg_n, dp_n, frame_done);
    end
    rst_n = 1'b1;
    load_word(16'h1234, 4'h0);
    wait_frame(to);
    checks++;
    if (to) begin
      failures++;
      $display("[TB] FAIL reset_frame_timeout: frame_done never seen");
    end
    load_word(16'hABCD, 4'hF);
    repeat (3) @(negedge clk);
    checks++;
    if (an_n !== 4'hE || digit_value !== 4'h4 || load_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL pre_reset_show: an_n=%h digit_value=%h ready=%b, want E 4 0",
               an_n, digit_value, load_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (an_n !== 4'hF || seg_n !== 7'h7F || dp_n !== 1'b1 || frame_done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL async_reset_outputs: an_n=%h seg_n=%h dp_n=%b fd=%b, want F 7f 1 0",
               an_n, seg_n, dp_n, frame_done);
    end
    checks++;
    if (digit_value !== 4'h0 || load_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL async_reset_state: digit_value=%h ready=%b, want 0 1",
               digit_value, load_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (load_ready !== 1'b1 || an_n !== 4'hF) begin
      failures++;
      $display("[TB] FAIL post_reset: ready=%b an_n=%h, want 1 F", load_ready, an_n);
    end
  endtask

  task automatic test_digits();
    bit to;
    logic [6:0] segs [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
    logic [3:0] ea;
    logic [6:0] es;
    int s, p;
    lz_suppress = 1'b0;
    wait_frame(to);
    load_word(16'h1234, 4'h0);
    wait_frame(to);
    checks++;
    if (to) begin
      failures++;
      $display("[TB] FAIL digits_timeout: frame_done never seen");
    end
    capture_frame();
    for (int e = 0; e < FRAME; e++) begin
      s  = e / RD;
      p  = e % RD;
      ea = (p < BC) ? 4'hF : (4'hF ^ (4'b0001 << s));
      es = (p < BC) ? 7'h7F : segs[s];
      checks++;
      if (an_s[e] !== ea || seg_s[e] !== es || dp_s[e] !== 1'b1 || fd_s[e] !== (e == FRAME - 1)) begin
        failures++;
        $display("[TB] FAIL digits_cycle%0d: an=%h seg=%h dp=%b fd=%b, want %h %h 1 %b",
                 e, an_s[e], seg_s[e], dp_s[e], fd_s[e], ea, es, (e == FRAME - 1));
      end
    end
  endtask

  task automatic test_lz_suppress();
    bit to;
    logic [6:0] segs5 [4] = '{7'h12, 7'h7F, 7'h7F, 7'h7F};
    logic [6:0] segs0 [4] = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
    logic [3:0] ea;
    logic [6:0] es;
    int s, p;
    lz_suppress = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      wait_frame(to);
      load_word((pass == 0) ? 16'h0005 : 16'h0000, 4'h0);
      wait_frame(to);
      checks++;
      if (to) begin
        failures++;
        $display("[TB] FAIL lz_timeout%0d: frame_done never seen", pass);
      end
      capture_frame();
      for (int e = 0; e < FRAME; e++) begin
        s  = e / RD;
        p  = e % RD;
        ea = (p < BC) ? 4'hF : (4'hF ^ (4'b0001 << s));
        es = (p < BC) ? 7'h7F : ((pass == 0) ? segs5[s] : segs0[s]);
        checks++;
        if (an_s[e] !== ea || seg_s[e] !== es) begin
          failures++;
          $display("[TB] FAIL lz%0d_cycle%0d: an=%h seg=%h, want %h %h",
                   pass, e, an_s[e], seg_s[e], ea, es);
        end
      end
    end
    lz_suppress = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit to, found, early;
    logic [6:0] segs_a [4] = '{7'h21, 7'h46, 7'h03, 7'h08};
    logic [6:0] segs_b [4] = '{7'h79, 7'h40, 7'h40, 7'h40};
    logic [3:0] ea;
    logic [6:0] es;
    int s, p;
    wait_frame(to);
    load_value = 16'hABCD;
    load_dp    = 4'h0;
    load_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (load_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_a_accepted: ready=%b, want 0", load_ready);
    end
    load_value = 16'h0001;
    found = 1'b0;
    early = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        found = 1'b1;
        break;
      end
      if (load_ready !== 1'b0) early = 1'b1;
    end
    checks++;
    if (!found || early || load_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_ready_window: found=%b early=%b ready=%b, want 1 0 1",
               found, early, load_ready);
    end
    capture_frame();
    load_valid = 1'b0;
    checks++;
    if (rdy_s[0] !== 1'b0 || rdy_s[FRAME - 2] !== 1'b0 || rdy_s[FRAME - 1] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_b_pending: ready first=%b before_end=%b end=%b, want 0 0 1",
               rdy_s[0], rdy_s[FRAME - 2], rdy_s[FRAME - 1]);
    end
    for (int f = 0; f < 2; f++) begin
      if (f == 1) capture_frame();
      for (int e = 0; e < FRAME; e++) begin
        s  = e / RD;
        p  = e % RD;
        ea = (p < BC) ? 4'hF : (4'hF ^ (4'b0001 << s));
        es = (p < BC) ? 7'h7F : ((f == 0) ? segs_a[s] : segs_b[s]);
        checks++;
        if (an_s[e] !== ea || seg_s[e] !== es || fd_s[e] !== (e == FRAME - 1)) begin
          failures++;
          $display("[TB] FAIL b2b_frame%0d_cycle%0d: an=%h seg=%h fd=%b, want %h %h %b",
                   f, e, an_s[e], seg_s[e], fd_s[e], ea, es, (e == FRAME - 1));
        end
      end
    end
  endtask

  task automatic test_decimal_point();
    bit to;
    logic ed;
    int s, p;
    wait_frame(to);
    load_word(16'h1234, 4'b0100);
    wait_frame(to);
    checks++;
    if (to) begin
      failures++;
      $display("[TB] FAIL dp_timeout: frame_done never seen");
    end
    capture_frame();
    for (int e = 0; e < FRAME; e++) begin
      s  = e / RD;
      p  = e % RD;
      ed = !((p >= BC) && (s == 2));
      checks++;
      if (dp_s[e] !== ed) begin
        failures++;
        $display("[TB] FAIL dp_cycle%0d: dp_n=%b, want %b", e, dp_s[e], ed);
      end
    end
  endtask

  task automatic test_frame_end_load();
    bit to;
    logic [6:0] segs_old [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
    logic [6:0] segs_new [4] = '{7'h00, 7'h78, 7'h02, 7'h12};
    logic [3:0] ea;
    logic [6:0] es;
    logic       ed;
    int s, p;
    wait_frame(to);
    repeat (FRAME - 1) @(negedge clk);
    load_value = 16'h5678;
    load_dp    = 4'h0;
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    checks++;
    if (frame_done !== 1'b1 || load_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL fe_edge: fd=%b ready=%b, want 1 0", frame_done, load_ready);
    end
    for (int f = 0; f < 2; f++) begin
      capture_frame();
      for (int e = 0; e < FRAME; e++) begin
        s  = e / RD;
        p  = e % RD;
        ea = (p < BC) ? 4'hF : (4'hF ^ (4'b0001 << s));
        es = (p < BC) ? 7'h7F : ((f == 0) ? segs_old[s] : segs_new[s]);
        ed = !((f == 0) && (p >= BC) && (s == 2));
        checks++;
        if (an_s[e] !== ea || seg_s[e] !== es || dp_s[e] !== ed || fd_s[e] !== (e == FRAME - 1)) begin
          failures++;
          $display("[TB] FAIL fe_frame%0d_cycle%0d: an=%h seg=%h dp=%b fd=%b, want %h %h %b %b",
                   f, e, an_s[e], seg_s[e], dp_s[e], fd_s[e], ea, es, ed, (e == FRAME - 1));
        end
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_digits();
    test_lz_suppress();
    test_back_to_back();
    test_decimal_point();
    test_frame_end_load();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
